// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: two write requesters, stall input and the
// register-file write port with its contention counter.
interface wb_port_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              wr_stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sel;
    logic [7:0]        conflict_cnt;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, wr_stall,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, sel, conflict_cnt
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, wr_stall,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, sel, conflict_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write-port arbiter with alternating tie priority,
// one-cycle registered write beat and a saturating contention counter.
module wb_port_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input logic             Clk,
    input logic             Reset_n,
    wb_port_arbiter_if.slave bus
);
    typedef enum logic [0:0] {StPriA, StPriB} state_e;

    state_e            state_q, state_d;
    logic              grant_a, grant_b;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              sel_q, sel_d;
    logic [7:0]        cnt_q, cnt_d;

    // Grant decision; readies stay low in reset and while the port is stalled.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        state_d = state_q;
        if (Reset_n && !bus.wr_stall) begin
            unique case (state_q)
                StPriA: begin
                    if (bus.a_valid) begin
                        grant_a = 1'b1;
                        state_d = StPriB;
                    end else if (bus.b_valid) begin
                        grant_b = 1'b1;
                    end
                end
                StPriB: begin
                    if (bus.b_valid) begin
                        grant_b = 1'b1;
                        state_d = StPriA;
                    end else if (bus.a_valid) begin
                        grant_a = 1'b1;
                    end
                end
                default: state_d = StPriA;
            endcase
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        // Register 0 is hardwired: the beat is consumed but never strobed.
        if (grant_a) begin
            wr_en_d   = (bus.a_addr != '0);
            wr_addr_d = bus.a_addr;
            wr_data_d = bus.a_data;
            sel_d     = 1'b0;
        end else if (grant_b) begin
            wr_en_d   = (bus.b_addr != '0);
            wr_addr_d = bus.b_addr;
            wr_data_d = bus.b_data;
            sel_d     = 1'b1;
        end
        // Both valid always leaves one requester waiting, so it counts as contention.
        if (bus.a_valid && bus.b_valid && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StPriA;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sel_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.a_ready      = grant_a;
    assign bus.b_ready      = grant_b;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.sel          = sel_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a behavioural model
// of the grant rules, write latency and contention counter.
module tb_wb_port_arbiter;
    logic Clk;
    logic Reset_n;
    int   total;
    int   bad;

    // Reference model state
    bit       m_prio_b;
    bit       m_wr_en;
    bit [4:0] m_addr;
    bit [31:0] m_data;
    bit       m_sel;
    int       m_cnt;
    bit       last_ga;
    bit       last_gb;

    wb_port_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    wb_port_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio_b = 1'b0;
        m_wr_en  = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_sel    = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic idle_inputs();
        bus.a_valid  = 1'b0;
        bus.b_valid  = 1'b0;
        bus.a_addr   = '0;
        bus.b_addr   = '0;
        bus.a_data   = '0;
        bus.b_data   = '0;
        bus.wr_stall = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 0);
        chk({tag, "_sel"}, bus.sel, 0);
        chk({tag, "_cnt"}, bus.conflict_cnt, 0);
        chk({tag, "_a_ready"}, bus.a_ready, 0);
        chk({tag, "_b_ready"}, bus.b_ready, 0);
    endtask

    // Called at posedge+1; pulses reset between edges and returns before the negedge.
    task automatic pulse_reset(input string tag);
        #1 Reset_n = 1'b0;
        #1 chk_zero(tag);
        #1 Reset_n = 1'b1;
        model_reset();
    endtask

    // One cycle: check at negedge, advance the model past the next posedge.
    task automatic step();
        bit ga;
        bit gb;
        bit both;
        @(negedge Clk);
        ga = 0;
        gb = 0;
        both = bus.a_valid && bus.b_valid;
        if (Reset_n && !bus.wr_stall) begin
            if (both) begin
                if (m_prio_b) gb = 1; else ga = 1;
            end else if (bus.a_valid) begin
                ga = 1;
            end else if (bus.b_valid) begin
                gb = 1;
            end
        end
        chk("a_ready", bus.a_ready, ga);
        chk("b_ready", bus.b_ready, gb);
        chk("wr_en", bus.wr_en, m_wr_en);
        chk("wr_addr", bus.wr_addr, m_addr);
        chk("wr_data", bus.wr_data, m_data);
        chk("sel", bus.sel, m_sel);
        chk("conflict_cnt", bus.conflict_cnt, m_cnt);
        last_ga = ga;
        last_gb = gb;
        if (both && m_cnt < 255) m_cnt++;
        m_wr_en = 1'b0;
        if (ga) begin
            m_wr_en = (bus.a_addr != 0);
            m_addr  = bus.a_addr;
            m_data  = bus.a_data;
            m_sel   = 1'b0;
            // The priority holder hands priority over only when it wins.
            if (!m_prio_b) m_prio_b = 1'b1;
        end else if (gb) begin
            m_wr_en = (bus.b_addr != 0);
            m_addr  = bus.b_addr;
            m_data  = bus.b_data;
            m_sel   = 1'b1;
            if (m_prio_b) m_prio_b = 1'b0;
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        bit a_pend;
        bit b_pend;
        total = 0;
        bad   = 0;
        last_ga = 0;
        last_gb = 0;
        idle_inputs();
        model_reset();
        Reset_n = 1'b0;
        #2 chk_zero("reset");
        #6 Reset_n = 1'b1;

        // A alone, first edge after reset release.
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd3;
        bus.a_data  = 32'hAAAA_0001;
        step();
        idle_inputs();
        chk("r034_en", bus.wr_en, 1);
        chk("r034_addr", bus.wr_addr, 3);
        chk("r034_data", bus.wr_data, 32'hAAAA_0001);
        chk("r034_sel", bus.sel, 0);
        step();
        chk("r034_en_off", bus.wr_en, 0);

        // Continuous tie alternates A,B,A,B with no bubbles.
        pulse_reset("rst2");
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.a_addr  = 5'd1;
        bus.b_addr  = 5'd2;
        bus.a_data  = 32'h1111_0000;
        bus.b_data  = 32'h2222_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r035_en", bus.wr_en, 1);
            chk("r035_sel", bus.sel, i % 2);
        end
        chk("r035_cnt", bus.conflict_cnt, 4);
        idle_inputs();
        step();

        // Stall freezes grants but counts contention.
        pulse_reset("rst3");
        bus.a_valid  = 1'b1;
        bus.b_valid  = 1'b1;
        bus.a_addr   = 5'd7;
        bus.b_addr   = 5'd9;
        bus.wr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r036_en", bus.wr_en, 0);
        end
        chk("r036_cnt", bus.conflict_cnt, 3);
        bus.wr_stall = 1'b0;
        step();
        chk("r036_first", bus.sel, 0);
        chk("r036_first_en", bus.wr_en, 1);
        step();
        chk("r036_second", bus.sel, 1);
        idle_inputs();

        // Write to register 0 from B.
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd0;
        bus.b_data  = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        chk("r037_en", bus.wr_en, 0);
        chk("r037_sel", bus.sel, 1);
        chk("r037_data", bus.wr_data, 32'hDEAD_BEEF);
        step();

        // Counter saturation.
        pulse_reset("rst4");
        bus.a_valid  = 1'b1;
        bus.b_valid  = 1'b1;
        bus.wr_stall = 1'b1;
        for (int i = 0; i < 300; i++) step();
        chk("r038_sat", bus.conflict_cnt, 255);
        step();
        chk("r038_hold", bus.conflict_cnt, 255);

        // Async reset during a live beat, then tie goes to A.
        pulse_reset("rst5");
        bus.wr_stall = 1'b0;
        bus.b_valid  = 1'b0;
        bus.a_addr   = 5'd5;
        bus.a_data   = 32'h5555_AAAA;
        step();
        chk("r039_live", bus.wr_en, 1);
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd6;
        pulse_reset("r039");
        step();
        chk("r039_tie_a", bus.sel, 0);
        idle_inputs();
        step();

        // Randomized traffic with hold-until-ready requesters.
        a_pend = 0;
        b_pend = 0;
        for (int i = 0; i < 600; i++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend      = 1;
                bus.a_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.a_data  = $urandom;
            end
            if (!b_pend && $urandom_range(0, 2) != 0) begin
                b_pend      = 1;
                bus.b_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.b_data  = $urandom;
            end
            bus.a_valid  = a_pend;
            bus.b_valid  = b_pend;
            bus.wr_stall = ($urandom_range(0, 4) == 0);
            step();
            if (last_ga) a_pend = 0;
            if (last_gb) b_pend = 0;
        end
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter DATA_W, default 32, write-data width.
REQ-003 SHALL have a single clock and an active-low asynchronous reset (ports below).
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset_n  input  1  asynchronous active-low reset.
REQ-006 a_valid  input  1  requester A has a write pending.
REQ-007 a_ready  output  1  requester A accepted this cycle.
REQ-008 a_addr  input  ADDR_W  A destination register.
REQ-009 a_data  input  DATA_W  A write data.
REQ-010 b_valid / b_ready / b_addr / b_data: same as A, for requester B.
REQ-011 wr_stall  input  1  register-file port unavailable; no grants.
REQ-012 wr_en  output  1  register-file write strobe.
REQ-013 wr_addr  output  ADDR_W  register-file write address.
REQ-014 wr_data  output  DATA_W  register-file write data.
REQ-015 sel  output  1  source of the current wr_* beat: 0 = A, 1 = B.
REQ-016 conflict_cnt  output  8  saturating count of contention cycles.

Function
REQ-017 Handshake: a transfer occurs on a cycle with x_valid=1 and x_ready=1; x_addr/x_data are sampled on that edge.
REQ-018 x_valid, once asserted, SHALL be held with stable addr/data until x_ready; the block does not check this.
REQ-019 a_ready/b_ready SHALL be combinational from the valids, wr_stall and FSM state; at most one is high per cycle.
REQ-020 wr_stall=1 SHALL force a_ready=b_ready=0 and freeze the FSM.
REQ-021 FSM states: PRI_A (A wins ties) and PRI_B (B wins ties).
REQ-022 PRI_A: a_valid grants A, then goes to PRI_B; else b_valid grants B and stays in PRI_A; else it holds.
REQ-023 PRI_B: b_valid grants B, then goes to PRI_A; else a_valid grants A and stays in PRI_B; else it holds.
REQ-024 Latency: a grant on edge N SHALL drive wr_en=1, wr_addr, wr_data and sel on the cycle after edge N, for exactly one cycle unless granted again.
REQ-025 Back-to-back grants SHALL produce wr_en=1 on consecutive cycles with no bubble.
REQ-026 A granted write with addr==0 SHALL be accepted (ready=1) but SHALL produce wr_en=0; wr_addr, wr_data and sel still update.
REQ-027 With no grant, wr_en=0; wr_addr, wr_data and sel hold their last values.
REQ-028 conflict_cnt SHALL increment on each cycle where a_valid=b_valid=1 and at least one requester is not granted (this includes stall); it saturates at 255 and does not wrap.
REQ-029 Equal addresses from A and B SHALL be written in grant order; the block applies no merging.

Reset
REQ-030 Reset_n=0 SHALL immediately force wr_en=0, wr_addr=0, wr_data=0, sel=0, conflict_cnt=0 and FSM=PRI_A, independent of Clk.
REQ-031 While Reset_n=0, a_ready=b_ready=0.
REQ-032 Reset mid-operation SHALL drop any beat granted but not yet presented; requesters re-present after reset release.
REQ-033 The first grant SHALL be possible on the first rising edge with Reset_n=1.

Verification
REQ-034 After reset, A only: a_valid=1, a_addr=3, a_data=0xAAAA0001 for one grant -> next cycle wr_en=1, wr_addr=3, wr_data=0xAAAA0001, sel=0; the cycle after, wr_en=0.
REQ-035 Both valid continuously, 4 cycles from reset (a_addr=1, b_addr=2) -> grants A,B,A,B; sel=0,1,0,1 with wr_en=1 on 4 consecutive cycles; conflict_cnt=4.
REQ-036 Stall: both valid with wr_stall=1 for 3 cycles -> no ready, wr_en=0, FSM unchanged; conflict_cnt=3; after release, the priority holder is granted first.
REQ-037 Zero register: b_valid=1, b_addr=0 -> b_ready=1; the next cycle wr_en=0 and sel=1.
REQ-038 Saturation: both valid with wr_stall=1 for 300 cycles -> conflict_cnt=255 and it stays 255.
REQ-039 Async reset: assert Reset_n=0 mid-cycle while wr_en=1 -> wr_en, wr_addr, wr_data, sel and conflict_cnt go to 0 before the next edge; the first post-reset tie goes to A.
